// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/dmem_grant.sv
// Combinational grant for the two SRAM requesters; grants are one-hot or zero.
module dmem_grant
  import dmem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  state_e           state_i,
  input  logic             p0_valid_i,
  input  logic             p1_valid_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  output logic             grant0_o,
  output logic             grant1_o
);

  always_comb begin
    grant0_o = 1'b0;
    grant1_o = 1'b0;
    if (state_i == ST_RUN) begin
      // p1 wins when p0 is idle or once p1 has been starved long enough
      grant1_o = p1_valid_i && (!p0_valid_i || (starve_cnt_i == CNT_W'(STARVE_MAX)));
      grant0_o = p0_valid_i && !grant1_o;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data SRAM arbiter: post-reset zero-fill, then one CPU/debug access per cycle
// with a registered response owner routing the 1-cycle-latency read data.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_we,
  input  logic [3:0]        p0_be,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_rsp_valid,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_we,
  input  logic [3:0]        p1_be,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_rsp_valid,
  output logic [31:0]       p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              init_done
);

  localparam int unsigned WA_W  = ADDR_W - 2;
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  state_e           state_q;
  logic [WA_W-1:0]  init_cnt_q;
  logic             init_done_q;
  logic [CNT_W-1:0] starve_q, starve_d;
  owner_e           own_q, own_d;
  logic             rd_q, rd_d;
  logic [31:0]      rdata0_q, rdata1_q;
  logic             grant0, grant1;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^{p0_addr[1:0], p1_addr[1:0]};

  dmem_grant #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_grant (
    .state_i      (state_q),
    .p0_valid_i   (p0_req_valid),
    .p1_valid_i   (p1_req_valid),
    .starve_cnt_i (starve_q),
    .grant0_o     (grant0),
    .grant1_o     (grant1)
  );

  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;
  assign init_done    = init_done_q;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ST_INIT) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_be   = BE_ALL;
      mem_addr = init_cnt_q;
    end else if (grant0) begin
      mem_en    = 1'b1;
      mem_we    = p0_we;
      mem_be    = p0_be;
      mem_addr  = p0_addr[ADDR_W-1:2];
      mem_wdata = p0_wdata;
    end else if (grant1) begin
      mem_en    = 1'b1;
      mem_we    = p1_we;
      mem_be    = p1_be;
      mem_addr  = p1_addr[ADDR_W-1:2];
      mem_wdata = p1_wdata;
    end
  end

  always_comb begin
    starve_d = '0;
    if (state_q == ST_RUN && p1_req_valid && !grant1)
      starve_d = (starve_q == CNT_W'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
    own_d = grant0 ? OWN_P0 : (grant1 ? OWN_P1 : OWN_NONE);
    rd_d  = (grant0 && !p0_we) || (grant1 && !p1_we);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      starve_q    <= '0;
      own_q       <= OWN_NONE;
      rd_q        <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == '1) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
      starve_q <= starve_d;
      own_q    <= own_d;
      rd_q     <= rd_d;
      if (own_q == OWN_P0 && rd_q) rdata0_q <= mem_rdata;
      if (own_q == OWN_P1 && rd_q) rdata1_q <= mem_rdata;
    end
  end

  // Read data is live from the SRAM in the response cycle, then held.
  assign p0_rsp_valid = (own_q == OWN_P0);
  assign p1_rsp_valid = (own_q == OWN_P1);
  assign p0_rdata     = (own_q == OWN_P0 && rd_q) ? mem_rdata : rdata0_q;
  assign p1_rdata     = (own_q == OWN_P1 && rd_q) ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-enabled SRAM model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_we, p0_rsp_valid;
  logic [3:0]  p0_be;
  logic [9:0]  p0_addr;
  logic [31:0] p0_wdata, p0_rdata;
  logic        p1_req_valid, p1_req_ready, p1_we, p1_rsp_valid;
  logic [3:0]  p1_be;
  logic [9:0]  p1_addr;
  logic [31:0] p1_wdata, p1_rdata;
  logic        mem_en, mem_we, init_done;
  logic [3:0]  mem_be;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int unsigned vec  = 0;
  int unsigned errs = 0;
  logic [31:0] sram [0:255];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(10), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_we(p0_we),
    .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rdata(p0_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_we(p1_we),
    .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .init_done(init_done)
  );

  // Single-port SRAM model, garbage-filled so the zero-fill is observable
  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'hFFFF_FFFF;
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drv0(input logic v, input logic we, input logic [3:0] be,
                      input logic [9:0] a, input logic [31:0] wd);
    p0_req_valid = v; p0_we = we; p0_be = be; p0_addr = a; p0_wdata = wd;
  endtask

  task automatic drv1(input logic v, input logic we, input logic [3:0] be,
                      input logic [9:0] a, input logic [31:0] wd);
    p1_req_valid = v; p1_we = we; p1_be = be; p1_addr = a; p1_wdata = wd;
  endtask

  // Checks every zero-fill cycle, then that init_done rises after 256 edges
  task automatic init_sweep(input string tag);
    for (int i = 0; i < 256; i++) begin
      #1;
      chk({tag, "_fill"}, {mem_en, mem_we, mem_be, mem_wdata, mem_addr},
          {1'b1, 1'b1, 4'hF, 32'h0, i[7:0]});
      chk({tag, "_rdy_done"}, {p0_req_ready, p1_req_ready, init_done}, 3'b000);
      cycle();
    end
    #1;
    chk({tag, "_done"}, {init_done, mem_en}, 2'b10);
  endtask

  initial begin
    rst_n = 1'b0;
    drv0(0, 0, 4'h0, 10'h0, 32'h0);
    drv1(0, 0, 4'h0, 10'h0, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outs", {init_done, p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid},
        5'b00000);
    chk("reset_rdata", {p0_rdata, p1_rdata}, 64'h0);
    rst_n = 1'b1;

    // 1: zero-fill
    init_sweep("init");
    chk("fill_w0", sram[0], 32'h0);
    chk("fill_w255", sram[255], 32'h0);

    // 2: full write then read
    drv0(1, 1, 4'hF, 10'h010, 32'hDEAD_BEEF);
    #1;
    chk("t2_wr_rdy", {p0_req_ready, p1_req_ready, mem_en, mem_we, mem_addr}, {4'b1011, 8'h04});
    cycle();
    drv0(1, 0, 4'h0, 10'h010, 32'h0);
    #1;
    chk("t2_wr_rsp", {p0_rsp_valid, p1_rsp_valid, p0_req_ready}, 3'b101);
    chk("t2_wr_rdata", p0_rdata, 32'h0);
    cycle();
    drv0(0, 0, 4'h0, 10'h0, 32'h0);
    #1;
    chk("t2_rd_rsp", {p0_rsp_valid, p1_rsp_valid}, 2'b10);
    chk("t2_rd_data", p0_rdata, 32'hDEAD_BEEF);
    cycle();
    #1;
    chk("t2_idle", {p0_rsp_valid, mem_en}, 2'b00);
    chk("t2_hold", p0_rdata, 32'hDEAD_BEEF);

    // 3: partial byte-lane write
    drv0(1, 1, 4'b0101, 10'h020, 32'h1122_3344);
    #1;
    chk("t3_wr", {p0_req_ready, mem_be, mem_addr}, {1'b1, 4'b0101, 8'h08});
    cycle();
    drv0(1, 0, 4'h0, 10'h020, 32'h0);
    cycle();
    drv0(0, 0, 4'h0, 10'h0, 32'h0);
    #1;
    chk("t3_rd", {p0_rsp_valid, p0_rdata}, {1'b1, 32'h0022_0044});

    // be=0 write from p1 is acknowledged but changes nothing
    cycle();
    drv1(1, 1, 4'h0, 10'h020, 32'hFFFF_FFFF);
    #1;
    chk("be0_req", {p1_req_ready, mem_en, mem_we, mem_be}, 7'b1110000);
    cycle();
    drv1(0, 0, 4'h0, 10'h0, 32'h0);
    drv0(1, 0, 4'h0, 10'h020, 32'h0);
    #1;
    chk("be0_rsp", {p1_rsp_valid, p0_rsp_valid, p1_rdata}, {2'b10, 32'h0});
    cycle();
    drv0(0, 0, 4'h0, 10'h0, 32'h0);
    #1;
    chk("be0_keep", {p0_rsp_valid, p0_rdata}, {1'b1, 32'h0022_0044});
    cycle();

    // 4: contention, expect p0 x4 then p1 x1, repeating
    drv0(1, 0, 4'h0, 10'h000, 32'h0);
    drv1(1, 0, 4'h0, 10'h004, 32'h0);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t4_grant", {p0_req_ready, p1_req_ready},
          (k % 5 == 4) ? 2'b01 : 2'b10);
      if (k > 0)
        chk("t4_route", {p0_rsp_valid, p1_rsp_valid},
            ((k - 1) % 5 == 4) ? 2'b01 : 2'b10);
      cycle();
    end
    drv0(0, 0, 4'h0, 10'h0, 32'h0);
    drv1(0, 0, 4'h0, 10'h0, 32'h0);
    #1;
    chk("t4_last", {p0_rsp_valid, p1_rsp_valid, p1_rdata}, {2'b01, 32'h0});
    cycle();

    // 5: preload both ends of memory, then back-to-back reads
    drv0(1, 1, 4'hF, 10'h000, 32'h0000_00A5);
    cycle();
    drv0(0, 0, 4'h0, 10'h0, 32'h0);
    drv1(1, 1, 4'hF, 10'h3FC, 32'h0000_005A);
    #1;
    chk("t5_last_word", {p1_req_ready, mem_addr}, {1'b1, 8'hFF});
    cycle();
    drv1(0, 0, 4'h0, 10'h0, 32'h0);
    drv0(1, 0, 4'h0, 10'h000, 32'h0);
    cycle();
    drv0(0, 0, 4'h0, 10'h0, 32'h0);
    drv1(1, 0, 4'h0, 10'h3FC, 32'h0);
    #1;
    chk("t5_p0_rsp", {p0_rsp_valid, p1_rsp_valid, p0_rdata}, {2'b10, 32'h0000_00A5});
    cycle();
    drv1(0, 0, 4'h0, 10'h0, 32'h0);
    #1;
    chk("t5_p1_rsp", {p0_rsp_valid, p1_rsp_valid, p1_rdata}, {2'b01, 32'h0000_005A});
    chk("t5_p0_hold", p0_rdata, 32'h0000_00A5);
    cycle();

    // 6: reset right after a p1 read is accepted drops its response
    drv1(1, 0, 4'h0, 10'h3FC, 32'h0);
    #1;
    chk("t6_acc", p1_req_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drv1(0, 0, 4'h0, 10'h0, 32'h0);
    #1;
    chk("t6_drop", {p1_rsp_valid, p0_rsp_valid, init_done}, 3'b000);
    chk("t6_init", {mem_en, mem_we, mem_addr}, {2'b11, 8'h00});
    chk("t6_rdata", {p0_rdata, p1_rdata}, 64'h0);
    cycle();
    #1;
    chk("t6_still", {p1_rsp_valid, init_done}, 2'b00);
    rst_n = 1'b1;
    init_sweep("reinit");

    drv1(1, 0, 4'h0, 10'h3FC, 32'h0);
    cycle();
    drv1(0, 0, 4'h0, 10'h0, 32'h0);
    #1;
    chk("t6_refilled", {p1_rsp_valid, p1_rdata}, {1'b1, 32'h0});

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port, 32-bit-wide data SRAM between two requesters. Port 0 is the CPU MEM stage and port 1 is the debug/DMA loader. The block sequences a post-reset zero-fill of the SRAM, then arbitrates one access per cycle using a valid/ready request handshake. It routes each 1-cycle-latency response back to the port that issued the request. The CPU pipeline uses the inverse of p0_req_ready as its MEM-stage stall.

Parameters:
ADDR_W, 10, byte-address width; SRAM depth is 2**(ADDR_W-2) words.
STARVE_MAX, 4, consecutive cycles p1 may be denied before it gets forced priority.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
p0_req_valid  in  1  CPU request valid
p0_req_ready  out  1  CPU request accepted this cycle
p0_we  in  1  1 = write, 0 = read
p0_be  in  4  byte-lane enables for writes
p0_addr  in  ADDR_W  byte address; bits [1:0] ignored
p0_wdata  in  32  write data, lane-aligned
p0_rsp_valid  out  1  response pulse
p0_rdata  out  32  read data
p1_req_valid, p1_req_ready, p1_we, p1_be, p1_addr, p1_wdata, p1_rsp_valid, p1_rdata  same as p0, for the debug/DMA port
mem_en  out  1  SRAM access strobe
mem_we  out  1  SRAM write
mem_be  out  4  SRAM byte enables
mem_addr  out  ADDR_W-2  SRAM word index
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data, valid the cycle after a read strobe
init_done  out  1  high once zero-fill is complete

Behaviour:
- Reset (async, rst_n low):
  - State goes to INIT and the init counter clears to 0.
  - init_done=0; both req_ready=0; both rsp_valid=0; both rdata=0.
  - starve_cnt=0; pending-response owner cleared.
- FSM has two states, INIT and RUN.
- INIT:
  - Each cycle: mem_en=1, mem_we=1, mem_be=4'hF, mem_wdata=0, mem_addr=counter.
  - Counter increments each cycle. At counter = DEPTH-1 (after that write), move to RUN and set init_done=1 (registered).
  - Both ready signals stay low throughout INIT.
  - Zero-fill takes exactly DEPTH cycles: 256 at default.
- RUN arbitration (combinational grant, registered response path):
  - Default: p0 wins whenever p0_req_valid=1.
  - Forced priority: if starve_cnt == STARVE_MAX and p1_req_valid=1, p1 wins even if p0 is valid.
  - pX_req_ready = grant to X. At most one ready is high per cycle.
  - A ready is never high when its valid is low.
  - The granted request drives the mem_* outputs in the same cycle; mem_addr = addr[ADDR_W-1:2].
  - With no grant, mem_en=0 and the other mem_* outputs are don't-care; hold them at 0.
- starve_cnt update:
  - Increments, saturating at STARVE_MAX, in each cycle where p1_req_valid=1 and p1 is not granted.
  - Clears on a p1 grant or whenever p1_req_valid=0.
- Response path:
  - Every accepted request, read or write, produces exactly one pXrsp_valid pulse on the owner port, in the cycle after acceptance.
  - For a read, pX_rdata = mem_rdata, captured that cycle and held until the next response to the same port.
  - For a write, rdata is unchanged.
  - There is no response back-pressure.
  - Back-to-back accepted requests yield back-to-back responses, so sustained throughput is 1 per cycle.
- Write with be=0: mem_en=1, mem_we=1, mem_be=0. It is acknowledged normally with no data change.
- Requester obligation: request fields must be held stable while valid=1 and ready=0. The block does not latch unaccepted requests.
- Reset mid-operation: an in-flight response is dropped (no rsp_valid) and INIT restarts from address 0.
- Address wrap: the upper bits above ADDR_W do not exist; p0_addr = 2**ADDR_W-4 targets the last word.

Decomposition:
- Shared package dmem_pkg holds:
  - enum/localparams ST_INIT, ST_RUN.
  - localparam BE_ALL = 4'hF.
  - Response-owner encodings OWN_NONE, OWN_P0, OWN_P1.
- One sub-module, dmem_grant: pure combinational grant logic. Inputs are the two valids, starve_cnt, and state; outputs are grant0 and grant1. It is kept separate so it can be formally checked for one-hot-or-zero grants.

Test Plan:
1. Release reset, hold both valids low:
   - init_done rises exactly 256 cycles after the first RUN-eligible edge.
   - Every mem_addr 0..255 is written with 0 and mem_be=F.
   - Readies stay 0 throughout.
2. After init, p0 writes 0xDEADBEEF to 0x010 with be=F, then reads 0x010:
   - ready is high on each request.
   - p0_rsp_valid pulses the cycle after each request.
   - Read returns 0xDEADBEEF.
3. p0 writes 0x11223344 to 0x020 with be=4'b0101, after a zero-filled init, then reads 0x020:
   - Read returns 0x00220044.
4. p0 and p1 both hold valid continuously:
   - p0 is granted 4 cycles, then p1 is granted 1 cycle, and the pattern repeats.
   - p1 is never denied more than 4 consecutive cycles.
5. p0 read, then p1 read on consecutive cycles, to 0x000 (preloaded 0xA5) and 0x3FC (preloaded 0x5A):
   - Responses are back-to-back with correct routing.
   - p1 receives no response for p0's request and vice versa.
6. Assert rst_n low during the cycle a p1 read is accepted:
   - No p1_rsp_valid occurs.
   - init_done=0 and state returns to INIT at address 0.
